// File: rtl/eoc_pkg.sv
// -----------------------------------------------------------------------------
// eoc_pkg
//   Shared definitions for the even_odd_checker slice.
//   - EOC_WIDTH / EOC_COUNT_W : default sample width and tally width.
//   - eoc_count_t             : default-width tally word; its $bits() supplies
//                               the COUNT_W parameter default.
//   - eoc_class_e             : registered classification, one-hot once a
//                               sample has been seen, all-zero before that.
//   - eoc_parity()            : XOR reduction of a sample (optional feature).
// -----------------------------------------------------------------------------
package eoc_pkg;

   localparam int unsigned EOC_WIDTH   = 8;
   localparam int unsigned EOC_COUNT_W = 16;

   typedef logic [EOC_COUNT_W-1:0] eoc_count_t;

   // Bit 1 drives 'even', bit 0 drives 'odd'.
   typedef enum logic [1:0] {
      CLS_NONE = 2'b00,
      CLS_ODD  = 2'b01,
      CLS_EVEN = 2'b10
   } eoc_class_e;

   // Only bit 0 of the sample decides the class.
   function automatic eoc_class_e eoc_classify(input logic lsb);
      return lsb ? CLS_ODD : CLS_EVEN;
   endfunction

   // 1 = odd number of ones in the 32-bit-extended word; zero extension
   // does not change the reduction.
   function automatic logic eoc_parity(input logic [31:0] word);
      return ^word;
   endfunction

endpackage : eoc_pkg

// File: rtl/eoc_sat_counter.sv
// -----------------------------------------------------------------------------
// eoc_sat_counter
//   Saturating up-counter with synchronous clear.
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset (count -> 0)
//     clr    : synchronous clear; takes priority over a plain increment
//     inc    : increment request; with clr on the same edge the count loads 1
//     count  : current tally, sticks at all-ones (never wraps)
//   Parameters:
//     COUNT_W : counter width (minimum 2)
// -----------------------------------------------------------------------------
module eoc_sat_counter
   import eoc_pkg::*;
#(
   parameter int unsigned COUNT_W = $bits(eoc_count_t)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               inc,
   output logic [COUNT_W-1:0] count
);

   localparam logic [COUNT_W-1:0] ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

   logic at_max;

   assign at_max = (count == '1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         // Clear first, then count the coincident sample.
         count <= inc ? ONE : '0;
      end else if (inc && !at_max) begin
         count <= count + ONE;
      end
   end

endmodule : eoc_sat_counter

// File: rtl/even_odd_checker.sv
// -----------------------------------------------------------------------------
// even_odd_checker
//   Classifies each valid unsigned sample as even or odd from its LSB,
//   registers the result with 1-cycle latency, and keeps saturating tallies
//   of even and odd samples.
//   Ports:
//     clk        : rising-edge clock
//     rst_n      : asynchronous active-low reset
//     in_valid   : n is accepted on this rising edge when high
//     n          : sample (unsigned, WIDTH bits)
//     clear      : synchronous clear of both tallies
//     out_valid  : one-cycle pulse after each accepted sample
//     even / odd : class of the last accepted sample (both 0 before the first)
//     even_count : saturating tally of even samples since reset/clear
//     odd_count  : saturating tally of odd samples since reset/clear
//     parity     : (EOC_PARITY_EN only) XOR of all bits of last accepted n
//   Parameters:
//     WIDTH   : sample width (minimum 1)
//     COUNT_W : tally width (minimum 2)
//   Configuration macro:
//     EOC_PARITY_EN : adds the registered 'parity' output.
// -----------------------------------------------------------------------------
module even_odd_checker
   import eoc_pkg::*;
#(
   parameter int unsigned WIDTH   = EOC_WIDTH,
   parameter int unsigned COUNT_W = $bits(eoc_count_t)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   n,
   input  logic               clear,
   output logic               out_valid,
   output logic               even,
   output logic               odd,
   output logic [COUNT_W-1:0] even_count,
`ifdef EOC_PARITY_EN
   output logic               parity,
`endif
   output logic [COUNT_W-1:0] odd_count
);

   eoc_class_e cls;
   logic       inc_even;
   logic       inc_odd;

   // Increments are qualified by in_valid so an X on n[0] while idle
   // never reaches the counters.
   assign inc_even = in_valid & ~n[0];
   assign inc_odd  = in_valid &  n[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cls       <= CLS_NONE;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            cls <= eoc_classify(n[0]);
         end
      end
   end

   assign even = cls[1];
   assign odd  = cls[0];

`ifdef EOC_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity <= 1'b0;
      end else if (in_valid) begin
         parity <= eoc_parity(32'(n));
      end
   end
`else
   // Upper sample bits only feed the optional parity output.
   if (WIDTH > 1) begin : g_unused_msbs
      logic unused_msbs;
      assign unused_msbs = ^n[WIDTH-1:1];
   end
`endif

   eoc_sat_counter #(
      .COUNT_W (COUNT_W)
   ) u_even_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clear),
      .inc   (inc_even),
      .count (even_count)
   );

   eoc_sat_counter #(
      .COUNT_W (COUNT_W)
   ) u_odd_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clear),
      .inc   (inc_odd),
      .count (odd_count)
   );

endmodule : even_odd_checker

// File: tb/tb_even_odd_checker.sv
module tb_even_odd_checker;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  n;
   logic        clear;

   logic        out_valid, even, odd;
   logic [15:0] even_count, odd_count;
   logic        s_out_valid, s_even, s_odd;
   logic [1:0]  s_even_count, s_odd_count;
`ifdef EOC_PARITY_EN
   logic        parity, s_parity;
`endif

   int compared;
   int mismatched;

   even_odd_checker #(
      .WIDTH   (8),
      .COUNT_W (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .n          (n),
      .clear      (clear),
      .out_valid  (out_valid),
      .even       (even),
      .odd        (odd),
      .even_count (even_count),
`ifdef EOC_PARITY_EN
      .parity     (parity),
`endif
      .odd_count  (odd_count)
   );

   even_odd_checker #(
      .WIDTH   (8),
      .COUNT_W (2)
   ) dut_sat (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .n          (n),
      .clear      (clear),
      .out_valid  (s_out_valid),
      .even       (s_even),
      .odd        (s_odd),
      .even_count (s_even_count),
`ifdef EOC_PARITY_EN
      .parity     (s_parity),
`endif
      .odd_count  (s_odd_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Main-DUT result/tally check.
   task automatic chk_main(input string tag, input logic ov, input logic ev, input logic od,
                           input logic [15:0] ec, input logic [15:0] oc);
      chk({tag, ".out_valid"},  32'(out_valid),  32'(ov));
      chk({tag, ".even"},       32'(even),       32'(ev));
      chk({tag, ".odd"},        32'(odd),        32'(od));
      chk({tag, ".even_count"}, 32'(even_count), 32'(ec));
      chk({tag, ".odd_count"},  32'(odd_count),  32'(oc));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      n        = '0;
      clear    = 1'b0;

      // Reset state
      step(); step();
      chk_main("reset", 0, 0, 0, 0, 0);
      chk("reset.sat_even", 32'(s_even_count), 32'd0);
      rst_n = 1'b1;
      step();
      chk_main("post_reset_idle", 0, 0, 0, 0, 0);

      // Basic classification
      in_valid = 1'b1;
      n = 8'd2;  step(); chk_main("n2",  1, 1, 0, 1, 0);
      n = 8'd3;  step(); chk_main("n3",  1, 0, 1, 1, 1);
      n = 8'd8;  step(); chk_main("n8",  1, 1, 0, 2, 1);
      n = 8'd15; step(); chk_main("n15", 1, 0, 1, 2, 2);

      // Idle hold with a different n on the bus
      in_valid = 1'b0;
      n = 8'd4;
      step(); chk_main("idle1", 0, 0, 1, 2, 2);
      step(); chk_main("idle2", 0, 0, 1, 2, 2);
      step(); chk_main("idle3", 0, 0, 1, 2, 2);
      in_valid = 1'b1;
      n = 8'd0; step(); chk_main("n0", 1, 1, 0, 3, 2);

      // Upper bits X: only n[0] classifies
      n = 8'bxxxx_xxx1; step(); chk_main("nx_odd", 1, 0, 1, 3, 3);

      // Bring counts to 5/3
      n = 8'd4; step();
      n = 8'd6; step(); chk_main("pre_rst", 1, 1, 0, 5, 3);

      // Asynchronous reset between edges
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk_main("async_rst", 0, 0, 0, 0, 0);
      in_valid = 1'b1;
      n = 8'd5;
      step(); chk_main("in_rst", 0, 0, 0, 0, 0);
      in_valid = 1'b0;
      #2 rst_n = 1'b1;
      step(); chk_main("rst_release", 0, 0, 0, 0, 0);
      in_valid = 1'b1;
      n = 8'd7; step(); chk_main("first_after_rst", 1, 0, 1, 0, 1);

      // Clear alone leaves even/odd, clears tallies
      in_valid = 1'b0;
      clear = 1'b1;
      step(); chk_main("clear_idle", 0, 0, 1, 0, 0);
      chk("clear_idle.sat_odd", 32'(s_odd_count), 32'd0);
      clear = 1'b0;

      // Saturation on the COUNT_W=2 instance
      in_valid = 1'b1;
      n = 8'd2;  step(); chk("sat1.even_count", 32'(s_even_count), 32'd1);
      n = 8'd4;  step(); chk("sat2.even_count", 32'(s_even_count), 32'd2);
      n = 8'd6;  step(); chk("sat3.even_count", 32'(s_even_count), 32'd3);
      n = 8'd8;  step(); chk("sat4.even_count", 32'(s_even_count), 32'd3);
      n = 8'd10; step(); chk("sat5.even_count", 32'(s_even_count), 32'd3);
      chk("sat5.odd_count", 32'(s_odd_count), 32'd0);
      chk("sat5.even",      32'(s_even),      32'd1);
      chk_main("sat5.main", 1, 1, 0, 5, 0);

      // Clear collision at 4/4
      in_valid = 1'b0;
      clear = 1'b1;
      step();
      clear = 1'b0;
      in_valid = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         n = 8'(i);
         step();
      end
      chk_main("at_4_4", 1, 1, 0, 4, 4);
      clear = 1'b1;
      n = 8'd9;
      step(); chk_main("clear_collide", 1, 0, 1, 0, 1);
      chk("clear_collide.sat_even", 32'(s_even_count), 32'd0);
      chk("clear_collide.sat_odd",  32'(s_odd_count),  32'd1);
      clear = 1'b0;

      // Parity vectors (classification checked in every build)
      n = 8'b1011_0000; step();
      chk("b0.even", 32'(even), 32'd1);
      chk("b0.odd",  32'(odd),  32'd0);
`ifdef EOC_PARITY_EN
      chk("b0.parity", 32'(parity), 32'd1);
`endif
      n = 8'b0000_0011; step();
      chk("03.odd",  32'(odd),  32'd1);
      chk("03.even", 32'(even), 32'd0);
`ifdef EOC_PARITY_EN
      chk("03.parity", 32'(parity), 32'd0);
      n = 8'b0000_0111; step();
      chk("07.parity", 32'(parity), 32'd1);
      in_valid = 1'b0;
      n = 8'h00; step();
      chk("idle.parity_hold", 32'(parity), 32'd1);
`endif

      in_valid = 1'b0;
      step();
      chk("final.out_valid", 32'(out_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule : tb_even_odd_checker
